fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of FIFO word and output data.
REQ-002 Parameter: BURST_LEN, default 4, words per burst; used only when FIFO_READER_BURST_EN is defined; range 1..65535.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: enable  input  1  permits the block to start and continue reading.
REQ-006 Port: fifo_empty  input  1  empty flag of the upstream FIFO.
REQ-007 Port: fifo_half  input  1  half flag of the upstream FIFO.
REQ-008 Port: fifo_full  input  1  full flag of the upstream FIFO.
REQ-009 Port: fifo_data  input  DATA_WIDTH  upstream FIFO read data, valid one cycle after an accepted read.
REQ-010 Port: fifo_ren  output  1  read enable to the upstream FIFO, combinational.
REQ-011 Port: m_valid  output  1  output word available.
REQ-012 Port: m_ready  input  1  downstream accepts the word.
REQ-013 Port: m_data  output  DATA_WIDTH  output word.
REQ-014 Port: rd_count  output  16  words delivered downstream, wraps modulo 2^16.
REQ-015 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The block SHALL hold a 2-entry output buffer plus one in-flight flag; credit = 2 - occupancy - inflight.
REQ-017 fifo_ren SHALL equal (state==STREAM) && !fifo_empty && credit>0 && (burst count < BURST_LEN when FIFO_READER_BURST_EN is defined).
REQ-018 A cycle with fifo_ren high SHALL set inflight; the following cycle SHALL write fifo_data into the buffer tail and clear inflight, unless a new read is also issued.
REQ-019 Back-to-back reads SHALL be sustained: with m_ready held high and the FIFO non-empty, one word per cycle after two cycles of initial latency.
REQ-020 m_valid SHALL be high iff occupancy>0; m_data SHALL be the oldest entry and held stable while m_valid && !m_ready.
REQ-021 A capture and a handshake in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-022 rd_count SHALL increment by 1 on each m_valid && m_ready; 0xFFFF wraps to 0x0000.
REQ-023 FSM states IDLE, STREAM, DRAIN; IDLE->STREAM when enable and start condition (REQ-032/033) is true.
REQ-024 STREAM->DRAIN when enable is low, or fifo_empty is high with no read issued, or (burst mode) burst count reaches BURST_LEN.
REQ-025 DRAIN SHALL issue no reads and return to IDLE when occupancy==0 and inflight==0.
REQ-026 fifo_full SHALL be used only as a start condition; it SHALL NOT gate reads.

Reset
REQ-027 On reset high at a clock edge: state IDLE, fifo_ren 0, m_valid 0, m_data 0, rd_count 0, busy 0, occupancy 0, inflight 0, burst count 0.
REQ-028 Reset mid-operation SHALL discard buffered and in-flight words; data returned by the FIFO the cycle after reset SHALL NOT be captured.
REQ-029 fifo_ren SHALL be 0 during any cycle in which reset is high.

Configuration
REQ-030 The macro FIFO_READER_BURST_EN selects burst mode.
REQ-031 With FIFO_READER_BURST_EN: a burst counter SHALL count issued reads, reset to 0 on IDLE->STREAM.
REQ-032 With FIFO_READER_BURST_EN: the start condition SHALL be fifo_half || fifo_full; STREAM ends after BURST_LEN reads or on empty.
REQ-033 Without FIFO_READER_BURST_EN: the start condition SHALL be !fifo_empty; no burst counter exists; STREAM runs until empty or enable low.

Verification
REQ-034 FIFO preloaded 0x11,0x22,0x33, enable=1, m_ready=1 -> m_data 0x11,0x22,0x33 on consecutive cycles, rd_count=3, busy returns 0.
REQ-035 Same preload, m_ready=0 for 5 cycles -> exactly 2 reads issued, m_data holds 0x11 stable, no words lost after m_ready=1.
REQ-036 m_ready toggling every cycle with 8 words -> all 8 delivered in order, fifo_ren never high with credit 0.
REQ-037 Reset asserted the cycle after a read -> m_valid 0, rd_count 0, returned word not delivered, state IDLE.
REQ-038 rd_count preset by 65535 handshakes then one more -> rd_count=0x0000.
REQ-039 FIFO_READER_BURST_EN, BURST_LEN=4, FIFO holds 6 words with half high -> exactly 4 words delivered, then IDLE until half reasserts.

Source files
------------

// File: rtl/fifo_reader.sv
// fifo_reader: drains an upstream FIFO (1-cycle read latency) into a 2-entry output buffer
// with a valid/ready output. Burst mode is compiled in with `define FIFO_READER_BURST_EN.
module fifo_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic                  fifo_half,
   input  logic                  fifo_full,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_ren,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [15:0]           rd_count,
   output logic                  busy,
   output logic [1:0]            state_o
);

   // Output handshake: a word moves downstream on every cycle where m_valid && m_ready;
   // m_valid never depends on m_ready, and m_data is held while m_valid && !m_ready.

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q, inflight_d;
   logic [DATA_WIDTH-1:0] buf_q [2];
   logic [DATA_WIDTH-1:0] buf_d [2];
   logic [15:0]           rd_count_q, rd_count_d;

   logic                  pop;
   logic [1:0]            credit;
   logic                  room;
   logic                  start;
   logic                  ren;

   if (BURST_LEN < 1 || BURST_LEN > 65535) begin : g_burst_len_check
      $error("fifo_reader: BURST_LEN must be in 1..65535");
   end

`ifdef FIFO_READER_BURST_EN
   localparam logic [15:0] BURST_LIM = 16'(BURST_LEN);
   logic [15:0] burst_q, burst_d;
`else
   logic unused_flags;
   assign unused_flags = fifo_half ^ fifo_full;
`endif

   // A slot freed by this cycle's handshake counts as credit, which is what lets
   // occupancy 1 + inflight 1 keep issuing one read per cycle under m_ready.
   always_comb begin
      pop    = (occ_q != 2'd0) && m_ready;
      credit = 2'd2 - occ_q - {1'b0, inflight_q};
      room   = (credit != 2'd0) || pop;
`ifdef FIFO_READER_BURST_EN
      start  = fifo_half || fifo_full;
      ren    = !reset && (state_q == ST_STREAM) && !fifo_empty && room && (burst_q < BURST_LIM);
`else
      start  = !fifo_empty;
      ren    = !reset && (state_q == ST_STREAM) && !fifo_empty && room;
`endif
   end

   always_comb begin
      state_d = state_q;
`ifdef FIFO_READER_BURST_EN
      burst_d = ren ? (burst_q + 16'd1) : burst_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (enable && start) begin
               state_d = ST_STREAM;
`ifdef FIFO_READER_BURST_EN
               burst_d = '0;
`endif
            end
         end
         ST_STREAM: begin
            if (!enable || (fifo_empty && !ren)) state_d = ST_DRAIN;
`ifdef FIFO_READER_BURST_EN
            if (burst_d == BURST_LIM) state_d = ST_DRAIN;
`endif
         end
         ST_DRAIN: begin
            if ((occ_q == 2'd0) && !inflight_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Entry 0 is always the oldest word; a returning read lands behind whatever survives the pop.
   always_comb begin
      buf_d      = buf_q;
      occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
      inflight_d = ren;
      rd_count_d = rd_count_q + {15'd0, pop};
      if (pop) buf_d[0] = buf_q[1];
      if (inflight_q) begin
         if ((occ_q == 2'd1) && !pop) buf_d[1] = fifo_data;
         else                         buf_d[0] = fifo_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q      <= '0;
         inflight_q <= 1'b0;
         buf_q[0]   <= '0;
         buf_q[1]   <= '0;
         rd_count_q <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         buf_q[0]   <= buf_d[0];
         buf_q[1]   <= buf_d[1];
         rd_count_q <= rd_count_d;
      end
   end

`ifdef FIFO_READER_BURST_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         burst_q <= '0;
      end else begin
         burst_q <= burst_d;
      end
   end
`endif

   assign fifo_ren = ren;
   assign m_valid  = (occ_q != 2'd0);
   assign m_data   = buf_q[0];
   assign rd_count = rd_count_q;
   assign busy     = (state_q != ST_IDLE);
   assign state_o  = state_q;

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: random and directed stimulus against a queue-based model of the
// upstream FIFO and of the words owed downstream.
module tb_fifo_reader;

   localparam int DW       = 8;
   localparam int HALF_LVL = 4;
   localparam int FULL_LVL = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          fifo_empty = 1'b1;
   logic          fifo_half = 1'b0;
   logic          fifo_full = 1'b0;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_ren;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic [15:0]   rd_count;
   logic          busy;
   logic [1:0]    state_o;

   always #5 clk = ~clk;

   fifo_reader #(.DATA_WIDTH(DW), .BURST_LEN(4)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .fifo_empty(fifo_empty), .fifo_half(fifo_half), .fifo_full(fifo_full),
      .fifo_data(fifo_data), .fifo_ren(fifo_ren),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .rd_count(rd_count), .busy(busy), .state_o(state_o)
   );

   logic [DW-1:0] src_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] deliv_q[$];
   int            stamp_q[$];
   bit            inflight_m = 1'b0;
   logic [15:0]   cnt_m = '0;
   int            cyc = 0;
   int            n_reads = 0;
   bit            s_ren = 1'b0, s_pop = 1'b0, s_reset = 1'b0;
   int            n_cmp = 0, n_err = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic refresh_flags();
      fifo_empty = (src_q.size() == 0);
      fifo_half  = (src_q.size() >= HALF_LVL);
      fifo_full  = (src_q.size() >= FULL_LVL);
   endtask

   // Per-cycle compare against the model: buffered words, count, and read legality.
   always @(negedge clk) begin : compare
      s_reset = reset;
      s_ren   = fifo_ren;
      s_pop   = (exp_q.size() > 0) && m_ready;
      if (reset) begin
         check("ren_during_reset", 32'(fifo_ren), 0);
      end else if (fifo_ren) begin
         n_reads++;
         check("ren_while_empty", 32'(fifo_empty), 0);
         check("ren_without_credit",
               32'((exp_q.size() + int'(inflight_m) - int'(s_pop) + 1) <= 2), 1);
      end
      check("m_valid", 32'(m_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) check("m_data", 32'(m_data), 32'(exp_q[0]));
      check("rd_count", 32'(rd_count), 32'(cnt_m));
   end

   // One clock: advance the FIFO and the owed-word model, then leave time for drivers.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (s_reset) begin
         exp_q.delete();
         inflight_m = 1'b0;
         cnt_m      = '0;
      end else begin
         if (s_pop) begin
            deliv_q.push_back(exp_q.pop_front());
            stamp_q.push_back(cyc);
            cnt_m++;
         end
         if (inflight_m) exp_q.push_back(fifo_data);
         inflight_m = s_ren;
         if (s_ren) fifo_data = (src_q.size() > 0) ? src_q.pop_front() : '0;
      end
      refresh_flags();
      #1;
   endtask

   task automatic ticks(int n);
      repeat (n) tick();
   endtask

   task automatic wait_busy(logic val, int budget, string name);
      int i;
      i = 0;
      while (busy !== val && i < budget) begin
         tick();
         i++;
      end
      check(name, 32'(busy), 32'(val));
   endtask

   task automatic push(logic [DW-1:0] v);
      src_q.push_back(v);
      refresh_flags();
   endtask

   task automatic clear_log();
      deliv_q.delete();
      stamp_q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int r0;
      bit settled;
      logic [DW-1:0] pre [3];
      pre[0] = 8'h11; pre[1] = 8'h22; pre[2] = 8'h33;

      reset = 1'b1;
      ticks(2);
      reset = 1'b0;
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_m_data", 32'(m_data), 0);
      check("rst_rd_count", 32'(rd_count), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_state", 32'(state_o), 0);
      check("rst_ren", 32'(fifo_ren), 0);

`ifdef FIFO_READER_BURST_EN
      // Six words with half high: one burst of four, then idle until half returns.
      clear_log();
      for (int i = 0; i < 6; i++) push(8'(8'h40 + i));
      m_ready = 1'b1;
      enable  = 1'b1;
      wait_busy(1'b1, 10, "burst_start");
      wait_busy(1'b0, 40, "burst_done");
      check("burst_count", 32'(deliv_q.size()), 4);
      for (int i = 0; i < 4 && i < deliv_q.size(); i++) check("burst_word", 32'(deliv_q[i]), 32'(8'h40 + i));
      ticks(10);
      check("burst_stays_idle", 32'(busy), 0);
      check("burst_no_more", 32'(deliv_q.size()), 4);
      push(8'h46);
      push(8'h47);
      wait_busy(1'b1, 10, "burst_restart");
      wait_busy(1'b0, 40, "burst_done2");
      check("burst_total", 32'(deliv_q.size()), 8);
`else
      // Three words at full rate on consecutive cycles.
      clear_log();
      for (int i = 0; i < 3; i++) push(pre[i]);
      m_ready = 1'b1;
      enable  = 1'b1;
      wait_busy(1'b1, 10, "s1_start");
      wait_busy(1'b0, 40, "s1_done");
      check("s1_count", 32'(deliv_q.size()), 3);
      for (int i = 0; i < 3 && i < deliv_q.size(); i++) check("s1_word", 32'(deliv_q[i]), 32'(pre[i]));
      for (int i = 1; i < 3 && i < stamp_q.size(); i++) check("s1_back_to_back", 32'(stamp_q[i] - stamp_q[i-1]), 1);
      check("s1_rd_count", 32'(rd_count), 3);
      enable = 1'b0;

      // Downstream stalled: only two reads fit, head word held.
      clear_log();
      for (int i = 0; i < 3; i++) push(pre[i]);
      m_ready = 1'b0;
      enable  = 1'b1;
      r0 = n_reads;
      ticks(8);
      check("s2_reads", 32'(n_reads - r0), 2);
      check("s2_hold_valid", 32'(m_valid), 1);
      check("s2_hold_data", 32'(m_data), 32'h11);
      m_ready = 1'b1;
      wait_busy(1'b0, 40, "s2_done");
      check("s2_count", 32'(deliv_q.size()), 3);
      for (int i = 0; i < 3 && i < deliv_q.size(); i++) check("s2_word", 32'(deliv_q[i]), 32'(pre[i]));
      check("s2_rd_count", 32'(rd_count), 6);

      // m_ready toggling every cycle over eight words.
      clear_log();
      for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
      for (int i = 0; i < 100; i++) begin
         m_ready = ~m_ready;
         tick();
         if (i > 4 && busy === 1'b0) break;
      end
      check("s3_idle", 32'(busy), 0);
      check("s3_count", 32'(deliv_q.size()), 8);
      for (int i = 0; i < 8 && i < deliv_q.size(); i++) check("s3_word", 32'(deliv_q[i]), 32'(8'hA0 + i));

      // Reset in the cycle after a read: returned word must be dropped.
      enable  = 1'b0;
      m_ready = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) push(pre[i]);
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (s_ren) break;
      end
      check("s4_read_seen", 32'(s_ren), 1);
      reset  = 1'b1;
      enable = 1'b0;
      tick();
      reset = 1'b0;
      check("s4_m_valid", 32'(m_valid), 0);
      check("s4_rd_count", 32'(rd_count), 0);
      check("s4_busy", 32'(busy), 0);
      check("s4_state", 32'(state_o), 0);
      ticks(4);
      check("s4_still_empty", 32'(m_valid), 0);
      src_q.delete();
      refresh_flags();
`endif

      // Random traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         enable  = ($urandom_range(0, 9) != 0);
         m_ready = ($urandom_range(0, 3) != 0);
         reset   = ($urandom_range(0, 299) == 0);
         if (src_q.size() < 12 && $urandom_range(0, 2) == 0) push(8'($urandom));
         tick();
      end
      reset   = 1'b0;
      enable  = 1'b1;
      m_ready = 1'b1;
      settled = 1'b0;
      for (int i = 0; i < 600 && !settled; i++) begin
         tick();
`ifdef FIFO_READER_BURST_EN
         settled = (busy === 1'b0) && (src_q.size() < HALF_LVL);
`else
         settled = (busy === 1'b0) && (src_q.size() == 0);
`endif
      end
      check("rand_settled", 32'(settled), 1);
      check("rand_nothing_owed", 32'(exp_q.size()), 0);

`ifndef FIFO_READER_BURST_EN
      // rd_count wrap: 65535 handshakes then one more.
      enable = 1'b0;
      do_reset();
      clear_log();
      for (int i = 0; i < 65535; i++) src_q.push_back(8'(i));
      refresh_flags();
      enable = 1'b1;
      wait_busy(1'b1, 10, "wrap_start");
      wait_busy(1'b0, 70000, "wrap_done");
      check("wrap_ffff", 32'(rd_count), 32'hFFFF);
      push(8'h5A);
      wait_busy(1'b1, 10, "wrap_start2");
      wait_busy(1'b0, 40, "wrap_done2");
      check("wrap_zero", 32'(rd_count), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
